// File: rtl/aes_dec_seq.sv
// ============================================================================
// Module   : aes_dec_seq
// Purpose  : Valid/ready sequencer for a combinational AES-128 decrypt core.
//            Optional completed-block counter enabled by AES_DEC_BLKCNT_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module aes_dec_seq #(
    parameter int WAIT_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_cipher,
    input  logic [127:0] in_key,
    output logic [127:0] core_cipher,
    output logic [127:0] core_key,
    input  logic [127:0] core_plain,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_plain,
    output logic         busy
`ifdef AES_DEC_BLKCNT_EN
    ,
    output logic [CNT_W-1:0] blk_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    localparam logic [7:0] C_CNT_LOAD = 8'(WAIT_CYCLES - 1);

    state_t       state_q,       state_d;
    logic [7:0]   cnt_q,         cnt_d;
    logic [127:0] core_cipher_q, core_cipher_d;
    logic [127:0] core_key_q,    core_key_d;
    logic [127:0] out_plain_q,   out_plain_d;
    logic         out_valid_q,   out_valid_d;

    logic w_accept;
    logic w_out_hs;

    // out_ready feeds in_ready combinationally so HOLD can reload without a bubble
    assign in_ready = !flush && ((state_q == ST_IDLE) ||
                                 ((state_q == ST_HOLD) && out_ready));
    assign w_accept = in_valid && in_ready;
    assign w_out_hs = out_valid_q && out_ready && !flush;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        core_cipher_d = core_cipher_q;
        core_key_d    = core_key_q;
        out_plain_d   = out_plain_q;
        out_valid_d   = out_valid_q;

        if (flush) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            cnt_d       = 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_accept) begin
                        core_cipher_d = in_cipher;
                        core_key_d    = in_key;
                        cnt_d         = C_CNT_LOAD;
                        state_d       = ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == 8'd0) begin
                        out_plain_d = core_plain;
                        out_valid_d = 1'b1;
                        state_d     = ST_HOLD;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                ST_HOLD: begin
                    if (w_out_hs) begin
                        out_valid_d = 1'b0;
                        state_d     = ST_IDLE;
                        if (w_accept) begin
                            core_cipher_d = in_cipher;
                            core_key_d    = in_key;
                            cnt_d         = C_CNT_LOAD;
                            state_d       = ST_SETTLE;
                        end
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    cnt_d       = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 8'd0;
            core_cipher_q <= 128'd0;
            core_key_q    <= 128'd0;
            out_plain_q   <= 128'd0;
            out_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            core_cipher_q <= core_cipher_d;
            core_key_q    <= core_key_d;
            out_plain_q   <= out_plain_d;
            out_valid_q   <= out_valid_d;
        end
    end

    assign core_cipher = core_cipher_q;
    assign core_key    = core_key_q;
    assign out_plain   = out_plain_q;
    assign out_valid   = out_valid_q;
    assign busy        = (state_q != ST_IDLE);

`ifdef AES_DEC_BLKCNT_EN
    logic [CNT_W-1:0] blk_count_q, blk_count_d;

    // Wraps naturally; flush never clears it
    always_comb begin
        blk_count_d = blk_count_q;
        if (w_out_hs) begin
            blk_count_d = blk_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_count_q <= '0;
        end else begin
            blk_count_q <= blk_count_d;
        end
    end

    assign blk_count = blk_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_aes_dec_seq.sv
// Self-checking bench for aes_dec_seq: directed scenarios plus random traffic
// checked against a transaction/timestamp reference model.
`default_nettype none

module tb_aes_dec_seq;

    localparam int WAIT  = 2;
    localparam int CNT_W = 2;

    localparam logic [127:0] FIPS_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] FIPS_K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_P = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_cipher;
    logic [127:0] in_key;
    logic [127:0] core_cipher;
    logic [127:0] core_key;
    logic [127:0] core_plain;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_plain;
    logic         busy;
`ifdef AES_DEC_BLKCNT_EN
    logic [CNT_W-1:0] blk_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: block lifetime tracked by edge timestamps
    int           m_cyc;
    int           m_tdone;
    bit           m_pend;
    bit           m_vld;
    logic [127:0] m_cc, m_kk, m_plain;
    int           m_cnt;

    always #5 clk = ~clk;

    aes_dec_seq #(.WAIT_CYCLES(WAIT), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_cipher   (in_cipher),
        .in_key      (in_key),
        .core_cipher (core_cipher),
        .core_key    (core_key),
        .core_plain  (core_plain),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_plain   (out_plain),
        .busy        (busy)
`ifdef AES_DEC_BLKCNT_EN
        ,
        .blk_count   (blk_count)
`endif
    );

    // Behavioural stand-in for the decrypt core: exact on the FIPS vector,
    // a keyed bijection elsewhere so every block has a distinct plaintext.
    function automatic logic [127:0] ref_core(input logic [127:0] c, input logic [127:0] k);
        if (c == FIPS_C && k == FIPS_K) return FIPS_P;
        return c ^ {k[63:0], k[127:64]} ^ 128'h5a5a_0f0f_3c3c_a5a5_1234_5678_9abc_def0;
    endfunction

    assign core_plain = ref_core(core_cipher, core_key);

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pend  = 0;
        m_vld   = 0;
        m_cc    = '0;
        m_kk    = '0;
        m_plain = '0;
        m_cnt   = 0;
        m_cyc   = 0;
        m_tdone = 0;
    endtask

    task automatic check_outputs();
        chk("out_valid",   out_valid,   m_vld);
        chk("busy",        busy,        m_pend);
        chk("out_plain",   out_plain,   m_plain);
        chk("core_cipher", core_cipher, m_cc);
        chk("core_key",    core_key,    m_kk);
`ifdef AES_DEC_BLKCNT_EN
        chk("blk_count",   blk_count,   128'(m_cnt % (1 << CNT_W)));
`endif
    endtask

    // One clock: drive inputs, check in_ready, advance model, check after edge
    task automatic step(input logic v, input logic [127:0] c, input logic [127:0] k,
                        input logic ordy, input logic fl);
        logic exp_rdy;
        in_valid  = v;
        in_cipher = c;
        in_key    = k;
        out_ready = ordy;
        flush     = fl;
        #1;
        exp_rdy = !fl && (!m_pend || (m_vld && ordy));
        chk("in_ready", in_ready, exp_rdy);
        if (fl) begin
            m_pend = 0;
            m_vld  = 0;
        end else begin
            if (m_vld && ordy) begin
                m_cnt++;
                m_pend = 0;
                m_vld  = 0;
            end
            if (v && exp_rdy) begin
                m_pend  = 1;
                m_cc    = c;
                m_kk    = k;
                m_tdone = m_cyc + 1 + WAIT;
            end
            if (m_pend && !m_vld && (m_cyc + 1 == m_tdone)) begin
                m_vld   = 1;
                m_plain = ref_core(m_cc, m_kk);
            end
        end
        m_cyc++;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        logic [127:0] rc, rk;
        int           exp_tab [5];
        exp_tab   = '{1, 2, 3, 0, 1};
        rst_n     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_cipher = '0;
        in_key    = '0;
        model_reset();
        #2;

        // 1: reset values and in_ready after release
        do_reset();
        chk("rst_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;

        // 2: single FIPS block, latency WAIT edges
        step(1'b1, FIPS_C, FIPS_K, 1'b0, 1'b0);
        chk("lat_e0_valid", out_valid, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        chk("lat_e1_valid", out_valid, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        chk("lat_e2_valid", out_valid, 1'b1);
        chk("fips_plain", out_plain, FIPS_P);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        chk("idle_after_hs", busy, 1'b0);

        // 3: backpressure in HOLD
        step(1'b1, FIPS_C ^ 128'h1, FIPS_K, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, FIPS_C, FIPS_K, 1'b0, 1'b0);
        chk("bp_valid", out_valid, 1'b1);
        step(1'b0, '0, '0, 1'b1, 1'b0);

        // 4: back-to-back, no IDLE bubble
        step(1'b1, FIPS_C, FIPS_K, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        chk("b2b_first_valid", out_valid, 1'b1);
        step(1'b1, FIPS_C, FIPS_K, 1'b1, 1'b0);
        chk("b2b_no_bubble", busy, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        chk("b2b_second_valid", out_valid, 1'b1);
        chk("b2b_second_plain", out_plain, FIPS_P);
        step(1'b0, '0, '0, 1'b1, 1'b0);

        // 5: flush in SETTLE with cnt=1, then async reset mid-SETTLE
        step(1'b1, 128'hdead_beef, 128'h1234, 1'b0, 1'b0);
        step(1'b1, FIPS_C, FIPS_K, 1'b1, 1'b1);
        chk("flush_idle", busy, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        chk("flush_no_valid", out_valid, 1'b0);
        step(1'b1, FIPS_C, FIPS_K, 1'b0, 1'b0);
        #3;
        do_reset();
        step(1'b0, '0, '0, 1'b0, 1'b0);

`ifdef AES_DEC_BLKCNT_EN
        // 6: counter wrap at CNT_W=2
        for (int b = 0; b < 5; b++) begin
            step(1'b1, 128'(b), FIPS_K, 1'b0, 1'b0);
            step(1'b0, '0, '0, 1'b0, 1'b0);
            step(1'b0, '0, '0, 1'b0, 1'b0);
            step(1'b0, '0, '0, 1'b1, 1'b0);
            chk("blk_count_seq", blk_count, 128'(exp_tab[b]));
        end
`else
        chk("blk_tab_unused", 128'(exp_tab[3]), 128'(m_cnt * 0));
`endif

        // Random traffic with backpressure and occasional flush
        for (int i = 0; i < 600; i++) begin
            rc = {$urandom, $urandom, $urandom, $urandom};
            rk = {$urandom, $urandom, $urandom, $urandom};
            step(1'($urandom_range(0, 1)), rc, rk,
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
